lock_timer_ctrl: RTL and testbench

Sequences the shared tick pulse generator for the combination lock. It opens an inactivity window while a code is being entered and counts failed attempts. After MAX_FAILS failures it holds the lock in a timed lockout. It drives the pulse generator's run/counterReset inputs and consumes its tick; it sits between the keypad/code comparator and the display/top FSM.

---
 rtl/lock_timer_pkg.sv | 18 +
 rtl/tick_downcounter.sv | 38 +++
 rtl/lock_timer_ctrl.sv | 159 +++++++++++++++
 tb/tb_lock_timer_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lock_timer_pkg.sv
// Shared constants and state encoding for the combination-lock tick sequencer.
package lock_timer_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ENTRY   = 2'd1;
    localparam logic [1:0] LOCKOUT = 2'd2;

    localparam int DEF_ENTRY_TICKS   = 40;   // 10 s at 0.25 s per tick
    localparam int DEF_LOCKOUT_TICKS = 120;  // 30 s
    localparam int TICK_W            = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_ENTRY   = ENTRY,
        ST_LOCKOUT = LOCKOUT
    } state_e;

endpackage

// File: rtl/tick_downcounter.sv
// Loadable down-counter that steps once per tick and never wraps below zero.
module tick_downcounter #(
    parameter int TICK_W = lock_timer_pkg::TICK_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [TICK_W-1:0] load_val,
    input  logic              dec,
    output logic [TICK_W-1:0] count,
    output logic              is_one
);

    logic [TICK_W-1:0] count_q;
    logic [TICK_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign is_one = (count_q == TICK_W'(1));

endmodule

// File: rtl/lock_timer_ctrl.sv
// Entry-window / failed-attempt / lockout sequencer driving the shared tick generator.
module lock_timer_ctrl
    import lock_timer_pkg::*;
#(
    parameter int ENTRY_TICKS   = DEF_ENTRY_TICKS,
    parameter int LOCKOUT_TICKS = DEF_LOCKOUT_TICKS,
    parameter int MAX_FAILS     = 3,
    parameter int TICK_W        = lock_timer_pkg::TICK_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              key_press,
    input  logic              code_ok,
    input  logic              code_bad,
    input  logic              tick,
    output logic              tick_run,
    output logic              tick_clear,
    output logic              accept_input,
    output logic              entry_timeout,
    output logic              locked_out,
    output logic [1:0]        fail_count,
    output logic [TICK_W-1:0] ticks_left
);

    localparam logic [2:0]        MAX_FAILS_C   = 3'(MAX_FAILS);
    localparam logic [TICK_W-1:0] ENTRY_LOAD    = TICK_W'(ENTRY_TICKS);
    localparam logic [TICK_W-1:0] LOCKOUT_LOAD  = TICK_W'(LOCKOUT_TICKS);

    state_e      state_q, state_d;
    logic [1:0]  fail_q, fail_d;
    logic        tick_run_q, tick_run_d;
    logic        tick_clear_q, tick_clear_d;
    logic        accept_q, accept_d;
    logic        timeout_q, timeout_d;
    logic        locked_q, locked_d;

    logic              cnt_load;
    logic [TICK_W-1:0] cnt_load_val;
    logic              cnt_dec;
    logic              cnt_is_one;
    logic              restart;
    logic              fail_ev;

    tick_downcounter #(.TICK_W(TICK_W)) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (ticks_left),
        .is_one   (cnt_is_one)
    );

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        fail_d       = fail_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        timeout_d    = 1'b0;
        restart      = 1'b0;
        fail_ev      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (key_press) begin
                    state_d      = ST_ENTRY;
                    cnt_load     = 1'b1;
                    cnt_load_val = ENTRY_LOAD;
                    restart      = 1'b1;
                end
            end
            ST_ENTRY: begin
                if (code_bad) begin
                    fail_ev = 1'b1;
                end else if (code_ok) begin
                    state_d  = ST_IDLE;
                    fail_d   = 2'd0;
                    cnt_load = 1'b1;
                end else if (tick && cnt_is_one) begin
                    timeout_d = 1'b1;
                    fail_ev   = 1'b1;
                end else if (key_press) begin
                    // A coincident non-expiring tick is dropped: the window restarts.
                    cnt_load     = 1'b1;
                    cnt_load_val = ENTRY_LOAD;
                    restart      = 1'b1;
                end else if (tick) begin
                    cnt_dec = 1'b1;
                end

                if (fail_ev) begin
                    if (({1'b0, fail_q} + 3'd1) >= MAX_FAILS_C) begin
                        state_d      = ST_LOCKOUT;
                        fail_d       = MAX_FAILS_C[1:0];
                        cnt_load     = 1'b1;
                        cnt_load_val = LOCKOUT_LOAD;
                        restart      = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        fail_d   = fail_q + 2'd1;
                        cnt_load = 1'b1;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (tick) begin
                    if (cnt_is_one) begin
                        state_d  = ST_IDLE;
                        fail_d   = 2'd0;
                        cnt_load = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                fail_d   = 2'd0;
                cnt_load = 1'b1;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        tick_clear_d = restart || (state_d == ST_IDLE);
        tick_run_d   = (state_d != ST_IDLE);
        accept_d     = (state_d != ST_LOCKOUT);
        locked_d     = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fail_q       <= 2'd0;
            tick_run_q   <= 1'b0;
            tick_clear_q <= 1'b1;
            accept_q     <= 1'b1;
            timeout_q    <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fail_q       <= fail_d;
            tick_run_q   <= tick_run_d;
            tick_clear_q <= tick_clear_d;
            accept_q     <= accept_d;
            timeout_q    <= timeout_d;
            locked_q     <= locked_d;
        end
    end

    assign tick_run      = tick_run_q;
    assign tick_clear    = tick_clear_q;
    assign accept_input  = accept_q;
    assign entry_timeout = timeout_q;
    assign locked_out    = locked_q;
    assign fail_count    = fail_q;

endmodule

// File: tb/tb_lock_timer_ctrl.sv
// Directed bench for lock_timer_ctrl with ENTRY_TICKS=4, LOCKOUT_TICKS=3, MAX_FAILS=3.
module tb_lock_timer_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_press = 1'b0;
    logic       code_ok = 1'b0;
    logic       code_bad = 1'b0;
    logic       tick = 1'b0;
    logic       tick_run;
    logic       tick_clear;
    logic       accept_input;
    logic       entry_timeout;
    logic       locked_out;
    logic [1:0] fail_count;
    logic [7:0] ticks_left;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    lock_timer_ctrl #(
        .ENTRY_TICKS   (4),
        .LOCKOUT_TICKS (3),
        .MAX_FAILS     (3),
        .TICK_W        (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .key_press     (key_press),
        .code_ok       (code_ok),
        .code_bad      (code_bad),
        .tick          (tick),
        .tick_run      (tick_run),
        .tick_clear    (tick_clear),
        .accept_input  (accept_input),
        .entry_timeout (entry_timeout),
        .locked_out    (locked_out),
        .fail_count    (fail_count),
        .ticks_left    (ticks_left)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the edge.
    task automatic cycle(input logic kp, input logic ok, input logic bad, input logic tk);
        key_press = kp;
        code_ok   = ok;
        code_bad  = bad;
        tick      = tk;
        @(posedge clock);
        #1;
        key_press = 1'b0;
        code_ok   = 1'b0;
        code_bad  = 1'b0;
        tick      = 1'b0;
    endtask

    task automatic check_all(input string tag, input int run, input int clr, input int acc,
                             input int tmo, input int lck, input int fc, input int tl);
        check({tag, ".tick_run"},      int'(tick_run),      run);
        check({tag, ".tick_clear"},    int'(tick_clear),    clr);
        check({tag, ".accept_input"},  int'(accept_input),  acc);
        check({tag, ".entry_timeout"}, int'(entry_timeout), tmo);
        check({tag, ".locked_out"},    int'(locked_out),    lck);
        check({tag, ".fail_count"},    int'(fail_count),    fc);
        check({tag, ".ticks_left"},    int'(ticks_left),    tl);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check_all("reset", 0, 1, 1, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle(0, 0, 0, 0);
        check_all("idle", 0, 1, 1, 0, 0, 0, 0);

        // 1: key_press opens a window
        cycle(1, 0, 0, 0);
        check_all("t1.open", 1, 1, 1, 0, 0, 0, 4);
        cycle(0, 0, 0, 0);
        check_all("t1.hold", 1, 0, 1, 0, 0, 0, 4);

        // 2: three ticks then code_ok
        cycle(0, 0, 0, 1);
        check_all("t2.tick1", 1, 0, 1, 0, 0, 0, 3);
        cycle(0, 0, 0, 1);
        check_all("t2.tick2", 1, 0, 1, 0, 0, 0, 2);
        cycle(0, 0, 0, 1);
        check_all("t2.tick3", 1, 0, 1, 0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        check_all("t2.ok", 0, 1, 1, 0, 0, 0, 0);

        // 3: window expires after four ticks
        cycle(1, 0, 0, 0);
        check("t3.open.ticks_left", int'(ticks_left), 4);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1);
            check("t3.count.ticks_left", int'(ticks_left), 3 - i);
            check("t3.count.entry_timeout", int'(entry_timeout), 0);
        end
        cycle(0, 0, 0, 1);
        check_all("t3.expire", 0, 1, 1, 1, 0, 1, 0);
        cycle(0, 0, 0, 0);
        check_all("t3.after", 0, 1, 1, 0, 0, 1, 0);

        // Clear the failure count before the lockout run
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        check("pre4.fail_count", int'(fail_count), 0);

        // 4: three failures reach lockout; inputs ignored there
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check_all("t4.fail1", 0, 1, 1, 0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check_all("t4.fail2", 0, 1, 1, 0, 0, 2, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check_all("t4.lock", 1, 1, 0, 0, 1, 3, 3);
        cycle(1, 0, 0, 0);
        check_all("t4.kp_ignored", 1, 0, 0, 0, 1, 3, 3);
        cycle(0, 1, 0, 0);
        check_all("t4.ok_ignored", 1, 0, 0, 0, 1, 3, 3);
        cycle(0, 0, 0, 1);
        check("t4.lt1.ticks_left", int'(ticks_left), 2);
        cycle(0, 0, 0, 1);
        check("t4.lt2.ticks_left", int'(ticks_left), 1);
        check("t4.lt2.locked_out", int'(locked_out), 1);
        cycle(0, 0, 0, 1);
        check_all("t4.release", 0, 1, 1, 0, 0, 0, 0);

        // 5a: key_press with a tick at ticks_left==2 restarts the window
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("t5.pre.ticks_left", int'(ticks_left), 2);
        cycle(1, 0, 0, 1);
        check_all("t5.restart", 1, 1, 1, 0, 0, 0, 4);
        cycle(0, 0, 0, 0);
        check("t5.restart_end.tick_clear", int'(tick_clear), 0);

        // 5b: code_ok and code_bad together count as a failure
        cycle(0, 1, 1, 0);
        check_all("t5.both", 0, 1, 1, 0, 0, 1, 0);

        // 6: async reset mid-lockout with ticks_left==2
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check("t6.fail2", int'(fail_count), 2);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check("t6.lock.locked_out", int'(locked_out), 1);
        cycle(0, 0, 0, 1);
        check("t6.lock.ticks_left", int'(ticks_left), 2);
        #2;
        reset = 1'b1;
        #1;
        check_all("t6.async_reset", 0, 1, 1, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        cycle(1, 0, 0, 0);
        check_all("t6.fresh", 1, 1, 1, 0, 0, 0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
